// File: rtl/hpdcache_credit_tx_if.sv
// rtl/hpdcache_credit_tx_if.sv - producer and link signals of the credit transmitter
//
// Groups the producer handshake (w_i/wok_o/wdata_i) with the link to the
// remote receive FIFO (tx_valid_o/tx_data_o forward, credit_i backward).
// Signal names keep the transmitter's point of view.
//   master : the transmitter (hpdcache_credit_tx)
//   slave  : producer plus remote receiver environment
interface hpdcache_credit_tx_if #(
    parameter type data_t = logic
);
    logic  w_i;
    logic  wok_o;
    data_t wdata_i;
    logic  tx_valid_o;
    data_t tx_data_o;
    logic  credit_i;

    modport master (
        input  w_i,
        input  wdata_i,
        input  credit_i,
        output wok_o,
        output tx_valid_o,
        output tx_data_o
    );

    modport slave (
        output w_i,
        output wdata_i,
        output credit_i,
        input  wok_o,
        input  tx_valid_o,
        input  tx_data_o
    );
endinterface

// File: rtl/hpdcache_credit_tx.sv
// rtl/hpdcache_credit_tx.sv - credit-based transmitter into a remote receive FIFO
//
// Forwards producer items as one-cycle registered pulses and only sends while
// a credit is held, so the remote FIFO (CREDITS entries deep) cannot overflow.
// Ports:
//   clk_i        : clock, all state on the rising edge
//   rst_i        : synchronous active-high reset
//   bus          : producer handshake and link (hpdcache_credit_tx_if.master)
//   credit_cnt_o : credits currently held
//   idle_o       : all credits home and no pulse in flight
//   err_o        : sticky credit overflow flag
module hpdcache_credit_tx #(
    parameter int unsigned CREDITS = 4,
    parameter type data_t = logic,
    localparam int unsigned CNT_W = $clog2(CREDITS + 1)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    hpdcache_credit_tx_if.master bus,
    output logic [CNT_W-1:0] credit_cnt_o,
    output logic             idle_o,
    output logic             err_o
);
    if (CREDITS < 1) begin : g_bad_credits
        $error("hpdcache_credit_tx: CREDITS must be at least 1");
    end

    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CREDITS);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [CNT_W-1:0] credit_cnt_q;
    logic             tx_valid_q;
    data_t            tx_data_q;
    logic             err_q;
    logic             wok;
    logic             accept;

    // Send permission looks only at the registered count; a credit arriving
    // this cycle is usable next cycle, which keeps credit_i off the wok path.
    assign wok    = (credit_cnt_q != '0);
    assign accept = bus.w_i & wok;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            credit_cnt_q <= CNT_FULL;
            tx_valid_q   <= 1'b0;
            tx_data_q    <= '0;
            err_q        <= 1'b0;
        end else begin
            tx_valid_q <= accept;
            if (accept) begin
                tx_data_q <= bus.wdata_i;
            end

            // A send and a returned credit in the same cycle cancel out.
            if (accept && !bus.credit_i) begin
                credit_cnt_q <= credit_cnt_q - CNT_ONE;
            end else if (bus.credit_i && !accept) begin
                if (credit_cnt_q == CNT_FULL) begin
                    err_q <= 1'b1;
                end else begin
                    credit_cnt_q <= credit_cnt_q + CNT_ONE;
                end
            end
        end
    end

    assign bus.wok_o      = wok;
    assign bus.tx_valid_o = tx_valid_q;
    assign bus.tx_data_o  = tx_data_q;
    assign credit_cnt_o   = credit_cnt_q;
    assign idle_o         = (credit_cnt_q == CNT_FULL) & ~tx_valid_q;
    assign err_o          = err_q;
endmodule

// File: tb/tb_hpdcache_credit_tx.sv
// tb/tb_hpdcache_credit_tx.sv - directed and loopback bench for hpdcache_credit_tx
module tb_hpdcache_credit_tx;
    localparam int unsigned CREDITS = 4;
    localparam int unsigned CNT_W   = $clog2(CREDITS + 1);
    typedef logic [7:0] data_t;

    logic             clk_i = 1'b0;
    logic             rst_i;
    logic [CNT_W-1:0] credit_cnt_o;
    logic             idle_o;
    logic             err_o;

    int tests_run = 0;
    int tests_failed = 0;

    hpdcache_credit_tx_if #(.data_t(data_t)) bus ();

    hpdcache_credit_tx #(
        .CREDITS (CREDITS),
        .data_t  (data_t)
    ) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .bus          (bus),
        .credit_cnt_o (credit_cnt_o),
        .idle_o       (idle_o),
        .err_o        (err_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle_inputs();
        bus.w_i      = 1'b0;
        bus.wdata_i  = '0;
        bus.credit_i = 1'b0;
    endtask

    data_t fifo[$];
    data_t sent[$];

    initial begin
        logic  credit_pipe;
        logic  pop;
        data_t seq;
        data_t popped;
        int    guard;

        idle_inputs();
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;

        // Reset state
        check("rst_cnt", 32'(credit_cnt_o), 4);
        check("rst_valid", 32'(bus.tx_valid_o), 0);
        check("rst_data", 32'(bus.tx_data_o), 0);
        check("rst_err", 32'(err_o), 0);
        check("rst_wok", 32'(bus.wok_o), 1);
        check("rst_idle", 32'(idle_o), 1);

        // Overflow: credit while all credits are home
        bus.credit_i = 1'b1;
        tick();
        bus.credit_i = 1'b0;
        check("ovf_err", 32'(err_o), 1);
        check("ovf_cnt", 32'(credit_cnt_o), 4);
        check("ovf_idle", 32'(idle_o), 1);
        tick();
        check("ovf_err_sticky", 32'(err_o), 1);
        check("ovf_cnt_hold", 32'(credit_cnt_o), 4);

        // Burst to empty: 0xA0..0xA5, only four go out
        for (int k = 0; k < 6; k++) begin
            bus.w_i     = 1'b1;
            bus.wdata_i = data_t'(8'hA0 + k);
            check($sformatf("burst_wok_%0d", k), 32'(bus.wok_o), (k < 4) ? 1 : 0);
            tick();
            if (k < 4) begin
                check($sformatf("burst_valid_%0d", k), 32'(bus.tx_valid_o), 1);
                check($sformatf("burst_data_%0d", k), 32'(bus.tx_data_o), 32'(8'hA0 + k));
                check($sformatf("burst_cnt_%0d", k), 32'(credit_cnt_o), 32'(3 - k));
            end else begin
                check($sformatf("burst_novalid_%0d", k), 32'(bus.tx_valid_o), 0);
                check($sformatf("burst_hold_%0d", k), 32'(bus.tx_data_o), 32'h A3);
                check($sformatf("burst_cnt0_%0d", k), 32'(credit_cnt_o), 0);
            end
        end
        idle_inputs();
        check("burst_wok_end", 32'(bus.wok_o), 0);
        check("burst_idle", 32'(idle_o), 0);

        // Credit unblock
        bus.credit_i = 1'b1;
        tick();
        bus.credit_i = 1'b0;
        check("unblk_cnt", 32'(credit_cnt_o), 1);
        check("unblk_wok", 32'(bus.wok_o), 1);
        bus.w_i     = 1'b1;
        bus.wdata_i = 8'h55;
        tick();
        idle_inputs();
        check("unblk_valid", 32'(bus.tx_valid_o), 1);
        check("unblk_data", 32'(bus.tx_data_o), 32'h55);
        check("unblk_cnt0", 32'(credit_cnt_o), 0);
        tick();
        check("unblk_single", 32'(bus.tx_valid_o), 0);
        check("unblk_wok0", 32'(bus.wok_o), 0);

        // Bring the count to 2, then send and credit together
        bus.credit_i = 1'b1;
        tick();
        tick();
        bus.credit_i = 1'b0;
        check("sim_cnt_pre", 32'(credit_cnt_o), 2);
        bus.w_i      = 1'b1;
        bus.credit_i = 1'b1;
        bus.wdata_i  = 8'h77;
        tick();
        idle_inputs();
        check("sim_cnt", 32'(credit_cnt_o), 2);
        check("sim_valid", 32'(bus.tx_valid_o), 1);
        check("sim_data", 32'(bus.tx_data_o), 32'h77);

        // Count 1: send and credit together keeps count 1 and wok high
        bus.w_i     = 1'b1;
        bus.wdata_i = 8'h11;
        tick();
        check("c1_cnt_pre", 32'(credit_cnt_o), 1);
        bus.credit_i = 1'b1;
        bus.wdata_i  = 8'h22;
        tick();
        idle_inputs();
        check("c1_cnt", 32'(credit_cnt_o), 1);
        check("c1_wok", 32'(bus.wok_o), 1);
        check("c1_data", 32'(bus.tx_data_o), 32'h22);
        check("c1_err_still", 32'(err_o), 1);

        // Reset mid-burst at count 1 with a pulse in flight; credit in reset cycle ignored
        check("mid_valid_pre", 32'(bus.tx_valid_o), 1);
        rst_i        = 1'b1;
        bus.credit_i = 1'b1;
        tick();
        rst_i = 1'b0;
        idle_inputs();
        check("mid_cnt", 32'(credit_cnt_o), 4);
        check("mid_valid", 32'(bus.tx_valid_o), 0);
        check("mid_err", 32'(err_o), 0);
        check("mid_idle", 32'(idle_o), 1);
        check("mid_wok", 32'(bus.wok_o), 1);

        // Random loopback into a CREDITS-deep FIFO with a one-cycle credit wire
        credit_pipe = 1'b0;
        seq = 8'h00;
        for (int i = 0; i < 10000; i++) begin
            bus.w_i      = 1'($urandom_range(0, 1));
            bus.wdata_i  = seq;
            bus.credit_i = credit_pipe;
            pop = (fifo.size() > 0) && ($urandom_range(0, 2) != 0);

            check("lb_invariant",
                  32'(credit_cnt_o) + 32'(bus.tx_valid_o) + 32'(fifo.size()) + 32'(credit_pipe),
                  CREDITS);
            if (bus.tx_valid_o) begin
                check("lb_no_overflow", 32'(fifo.size() < CREDITS), 1);
            end
            if (bus.w_i && credit_cnt_o == 0) begin
                check("lb_no_underflow", 32'(bus.wok_o), 0);
            end

            if (bus.w_i && bus.wok_o) begin
                sent.push_back(seq);
                seq = seq + 8'd1;
            end
            if (pop) begin
                popped = fifo.pop_front();
                if (sent.size() == 0) begin
                    check("lb_spurious", 1, 0);
                end else begin
                    check("lb_order", 32'(popped), 32'(sent.pop_front()));
                end
            end
            if (bus.tx_valid_o) begin
                fifo.push_back(bus.tx_data_o);
            end
            credit_pipe = pop;
            tick();
        end

        // Drain
        bus.w_i = 1'b0;
        guard = 0;
        while ((fifo.size() > 0 || bus.tx_valid_o || credit_pipe) && guard < 100) begin
            bus.credit_i = credit_pipe;
            pop = (fifo.size() > 0);
            if (pop) begin
                popped = fifo.pop_front();
                if (sent.size() == 0) begin
                    check("drain_spurious", 1, 0);
                end else begin
                    check("drain_order", 32'(popped), 32'(sent.pop_front()));
                end
            end
            if (bus.tx_valid_o) begin
                fifo.push_back(bus.tx_data_o);
            end
            credit_pipe = pop;
            tick();
            guard++;
        end
        idle_inputs();
        tick();
        check("drain_timeout", 32'(guard < 100), 1);
        check("lb_all_delivered", 32'(sent.size()), 0);
        check("lb_err", 32'(err_o), 0);
        check("lb_idle", 32'(idle_o), 1);
        check("lb_cnt", 32'(credit_cnt_o), 4);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
